// File: rtl/bus_pkg.sv
// Shared definitions for the common-bus arbiter and its helpers.
//   state_t      : arbiter FSM state
//   MODE_*       : arbitration mode selectors
//   AR..MEM      : source indices, matching the legacy bus select codes
package bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  localparam int AR  = 1;
  localparam int PC  = 2;
  localparam int DR  = 3;
  localparam int AC  = 4;
  localparam int IR  = 5;
  localparam int TR  = 6;
  localparam int MEM = 7;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational winner select, reusable by any request arbiter.
//   req    in  N   request vector
//   ptr    in  IW  round-robin start index (ignored in fixed mode)
//   mode   in  1   0 = highest set bit wins, 1 = first set bit at/above ptr
//   onehot out N   winner as one-hot (0 when no request)
//   idx    out IW  winner index (0 when no request)
//   any    out 1   at least one request pending
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int   j;
    logic found;
    j      = 0;
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    any    = |req;
    if (!mode) begin
      // Ascending scan, so the last hit (highest index) wins.
      for (int i = 0; i < N; i++)
        if (req[i]) idx = IW'(i);
    end else begin
      // Scan N slots starting at ptr, wrapping back to 0.
      for (int k = 0; k < N; k++) begin
        j = int'(ptr) + k;
        if (j >= N) j = j - N;
        if (!found && req[j]) begin
          idx   = IW'(j);
          found = 1'b1;
        end
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: registered request/grant arbiter for the shared datapath bus.
//   clk, rst_n : clock, async active-low reset
//   req        : per-source level request, held until the transfer ends
//   src_rdy    : per-source data-ready; only the granted bit is looked at
//   src_data   : flattened source data, slice i = [i*DATA_W +: DATA_W]
//   grant      : registered one-hot grant
//   bus_data   : registered bus value, changes only on completion/timeout
//   bus_valid  : 1-cycle pulse, bus_data holds a completed transfer
//   bus_src    : source index of the last completed transfer
//   bus_err    : 1-cycle pulse on timeout (bus_data forced to 0)
//   busy       : a grant is outstanding
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                N_SRC       = 8,
  parameter int                NARROW_W    = 12,
  parameter logic [N_SRC-1:0]  NARROW_MASK = N_SRC'(8'b0000_0110),
  parameter int                MODE        = MODE_FIXED,
  parameter int                TIMEOUT     = 15,
  localparam int               IW          = $clog2(N_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SRC-1:0]          req,
  input  logic [N_SRC-1:0]          src_rdy,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  output logic [N_SRC-1:0]          grant,
  output logic [DATA_W-1:0]         bus_data,
  output logic                      bus_valid,
  output logic [IW-1:0]             bus_src,
  output logic                      bus_err,
  output logic                      busy
);

  state_t                         state;
  logic [IW-1:0]                  win;
  logic [IW-1:0]                  ptr;
  logic [7:0]                     cnt;
  logic [N_SRC-1:0]               pick_oh;
  logic [IW-1:0]                  pick_idx;
  logic                           pick_any;
  logic [N_SRC-1:0][DATA_W-1:0]   src_ext;

  rr_pick #(.N(N_SRC), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .mode   (MODE == MODE_RR),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Narrow sources (address-width registers) drive only their low bits.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_ext[i] = src_data[i*DATA_W +: DATA_W];
      if (NARROW_MASK[i])
        for (int b = NARROW_W; b < DATA_W; b++) src_ext[i][b] = 1'b0;
    end
  end

  assign busy = (state == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      win       <= '0;
      ptr       <= '0;
      cnt       <= '0;
      bus_data  <= '0;
      bus_valid <= 1'b0;
      bus_src   <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_valid <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick_oh;
            win   <= pick_idx;
            cnt   <= '0;
            state <= WAIT;
          end else begin
            grant <= '0;
          end
        end
        WAIT: begin
          // Completion beats timeout on the same cycle; a dropped request
          // aborts silently and leaves the rotation pointer alone.
          if (req[win] && src_rdy[win]) begin
            bus_data  <= src_ext[win];
            bus_src   <= win;
            bus_valid <= 1'b1;
            grant     <= '0;
            state     <= IDLE;
            ptr       <= (win == IW'(N_SRC-1)) ? '0 : win + 1'b1;
          end else if (!req[win]) begin
            grant <= '0;
            state <= IDLE;
          end else if (cnt == 8'(TIMEOUT)) begin
            bus_err  <= 1'b1;
            bus_data <= '0;
            grant    <= '0;
            state    <= IDLE;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Parametrised, registered common-bus arbiter for the basic computer datapath. It replaces static bus-code selection with request/grant arbitration among N_SRC register/memory sources. It supports fixed-priority or round-robin modes, wait states on slow sources (memory), zero-extension of narrow (address-width) sources, a timeout and a registered bus output. It sits between all register/memory read ports and the shared bus consumed by the register-load logic.

## Interface
Parameters:
- DATA_W, 16, bus width in bits.
- N_SRC, 8, number of sources, 2..16; source index i = bit i of req.
- NARROW_W, 12, width of narrow sources (AR, PC).
- NARROW_MASK, 8'b0000_0110, bit i set: source i is narrow, bits [DATA_W-1:NARROW_W] forced to 0.
- MODE, 0, 0 = fixed priority with highest index winning; 1 = round-robin.
- TIMEOUT, 15, maximum WAIT cycles before abort, 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_SRC  per-source request, level; must stay high until the transfer completes.
- src_rdy  in  N_SRC  per-source data-ready; 1 = src_data slice valid this cycle.
- src_data  in  N_SRC*DATA_W  flattened source data; slice i is [i*DATA_W +: DATA_W].
- grant  out  N_SRC  one-hot current grant, registered.
- bus_data  out  DATA_W  registered bus value.
- bus_valid  out  1  one-cycle pulse: bus_data holds a completed transfer.
- bus_src  out  $clog2(N_SRC)  index of the source of the last bus_data.
- bus_err  out  1  one-cycle pulse on timeout.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, WAIT.
- IDLE with req == 0: stay. Outputs grant = 0 and bus_valid = 0. bus_data holds its value.
- IDLE with req != 0: pick the winner w, grant <= onehot(w), load the timeout counter with 0, go to WAIT.
- WAIT with req[w] = 1 and src_rdy[w] = 1: complete the transfer:
  - bus_data <= slice w, zero-extended if NARROW_MASK[w].
  - bus_src <= w, bus_valid <= 1.
  - grant <= 0, go to IDLE.
- WAIT with req[w] = 0: abort. grant <= 0, go to IDLE, no bus_valid, no bus_err. The pointer is not updated.
- WAIT with counter == TIMEOUT and no completion: bus_err <= 1, bus_data <= 0, grant <= 0, go to IDLE.
- Otherwise the counter increments by 1; it saturates at 8 bits.
- Winner selection in fixed mode: highest set bit of req.
- Winner selection in round-robin mode: first set bit at or above ptr, wrapping modulo N_SRC.
  - ptr <= (w+1) mod N_SRC only on a completed transfer.
  - Aborts and timeouts leave ptr unchanged.
- src_rdy on non-granted sources is ignored. Requests arriving during WAIT are not considered until IDLE.
- grant is never multi-hot. A source whose req bit is 0 is never granted.

## Timing
- Reset values: state IDLE, grant 0, bus_data 0, bus_valid 0, bus_src 0, bus_err 0, busy 0, ptr 0, counter 0.
- Reset is asynchronous. Asserting rst_n low mid-WAIT drops grant immediately, and no bus_valid is produced.
- Latency, req rising to grant: 1 cycle.
- Latency, src_rdy sampled high in WAIT to bus_valid: 1 cycle.
- Minimum transfer (source ready at grant): req at edge t, grant at t+1, bus_valid at t+2.
- Back-to-back throughput: one transfer per 2 cycles.
- bus_valid and bus_err are mutually exclusive, each at most one cycle wide.
- bus_data is stable between completions and timeouts.

## Structure
- Shared package bus_pkg holds:
  - state enum {IDLE, WAIT}.
  - MODE_FIXED / MODE_RR constants.
  - default source index constants AR = 1, PC = 2, DR = 3, AC = 4, IR = 5, TR = 6, MEM = 7, matching the existing bus codes.
- One sub-module, rr_pick: combinational winner select (req, ptr, mode) -> one-hot and index. It is instantiated once and reusable by other arbiters.

## Test plan
- Fixed mode: req = 8'b1001_0000, AC = 16'h1234, MEM ready at grant -> grant = 8'b1000_0000 one cycle later, bus_data = MEM data, bus_src = 7. Then AC is granted, giving bus_data = 16'h1234, bus_src = 4.
- Narrow source: PC slice = 16'hF0A5, req = 8'b0000_0100 -> bus_data = 16'h00A5, bus_valid for 1 cycle.
- Round-robin: req = 8'b1000_0010 held through 4 transfers -> bus_src sequence 1, 7, 1, 7.
- Wait states: MEM granted, src_rdy[7] rises after 3 cycles -> bus_valid exactly 1 cycle after rdy is sampled. Then TIMEOUT = 15 with no rdy -> bus_err on cycle 16 of WAIT, bus_data = 0, grant = 0.
- Abort and reset: req dropped in WAIT -> IDLE, no pulses, ptr unchanged. rst_n low mid-WAIT -> grant = 0 immediately, all outputs at reset values.
